fb_write_arbiter: RTL

// - Shares the single frame-buffer write port (11-bit addr, 24-bit BGR data, 1-cycle wr_ena) between NUM_REQ pixel sources, e.g. pattern generator and host loader.
// - Round-robin grant with a bounded burst length; one write per accepted beat.
// - Owns the double-buffer swap: a beat tagged req_last commits the frame, toggles selected_buffer, and blocks all writers until the scan side reports actual_buffer == selected_buffer.

---
 rtl/fb_write_arbiter_pkg.sv | 17 +
 rtl/fb_write_arbiter_rr_arbiter.sv | 23 ++
 rtl/fb_write_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fb_write_arbiter_pkg.sv
// Shared frame-buffer geometry and arbiter state encodings.
package fb_write_arbiter_pkg;

  localparam int FB_ROW_W  = 5;
  localparam int FB_COL_W  = 6;
  localparam int FB_ADDR_W = FB_ROW_W + FB_COL_W;
  localparam int FB_DATA_W = 24;

  localparam logic [1:0] ARB_IDLE  = 2'b00;
  localparam logic [1:0] ARB_GRANT = 2'b01;
  localparam logic [1:0] ARB_SWAP  = 2'b10;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && valid[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin owner of the frame-buffer write port; also drives the double-buffer swap.
//   state     | meaning
//   ARB_IDLE  | bubble cycle, pick next owner from rr pointer
//   ARB_GRANT | owner streams beats, one write per accepted beat
//   ARB_SWAP  | frame committed, all writers blocked until scan side follows
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W,
  parameter int BURST_MAX = 64,
  parameter int GID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      wr_ena,
  output logic                      selected_buffer,
  input  logic                      actual_buffer,
  output logic                      swap_busy,
  output logic [GID_W-1:0]          grant_id
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  logic [1:0]        state_q, state_d;
  logic [GID_W-1:0]  grant_id_q, grant_id_d;
  logic [GID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_ena_q, wr_ena_d;
  logic              sel_buf_q, sel_buf_d;

  logic [GID_W-1:0]  pick_idx;
  logic              pick_found;
  logic              own_valid, own_last, accept, burst_done;
  logic [GID_W-1:0]  next_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(GID_W)) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    own_valid  = req_valid[grant_id_q];
    own_last   = req_last[grant_id_q];
    accept     = (state_q == ARB_GRANT) && own_valid;
    burst_done = (burst_cnt_q == CNT_W'(BURST_MAX - 1));
    next_ptr   = GID_W'(wrap_inc(int'(grant_id_q), NUM_REQ));
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ARB_GRANT) req_ready[grant_id_q] = own_valid;
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_ena_d    = 1'b0;
    sel_buf_d   = sel_buf_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d     = ARB_GRANT;
          grant_id_d  = pick_idx;
          burst_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (accept) begin
          wr_addr_d   = req_addr[int'(grant_id_q)*ADDR_W +: ADDR_W];
          wr_data_d   = req_data[int'(grant_id_q)*DATA_W +: DATA_W];
          wr_ena_d    = 1'b1;
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
        // commit wins over burst rotation, which wins over a dropped valid
        if (accept && own_last) begin
          state_d   = ARB_SWAP;
          sel_buf_d = ~sel_buf_q;
        end else if ((accept && burst_done) || !own_valid) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      ARB_SWAP: begin
        if (actual_buffer == sel_buf_q) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_ena_q    <= 1'b0;
      sel_buf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_ena_q    <= wr_ena_d;
      sel_buf_q   <= sel_buf_d;
    end
  end

  assign wr_addr         = wr_addr_q;
  assign wr_data         = wr_data_q;
  assign wr_ena          = wr_ena_q;
  assign selected_buffer = sel_buf_q;
  assign swap_busy       = (state_q == ARB_SWAP);
  assign grant_id        = grant_id_q;

endmodule
